// File: rtl/regfile_banked.sv
// Dual-bank (integer/float) register file with NREAD registered read ports, one write port,
// write-first bypass and a per-register busy scoreboard; a post-reset sweep zeroes storage.
module regfile_banked #(
    parameter  int XLEN  = 32,
    parameter  int NREG  = 32,
    parameter  int NREAD = 3,
    localparam int AW    = $clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  rstn,
    output logic                  ready,
    input  logic [NREAD-1:0]      rfmode,
    input  logic [NREAD*AW-1:0]   raddr,
    output logic [NREAD*XLEN-1:0] rdata,
    output logic [NREAD-1:0]      rbusy,
    input  logic                  wen,
    input  logic                  wfmode,
    input  logic [AW-1:0]         waddr,
    input  logic [XLEN-1:0]       wdata,
    input  logic                  resv_en,
    input  logic                  resv_fmode,
    input  logic [AW-1:0]         resv_addr
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t              state, state_nxt;
    logic [AW-1:0]       idx, idx_nxt;
    logic [XLEN-1:0]     mem [2][NREG];
    logic [1:0][NREG-1:0] busy, busy_nxt;
    logic                wr_act, rs_act;
    logic [NREAD*XLEN-1:0] rdata_nxt;
    logic [NREAD-1:0]      rbusy_nxt;

    assign ready = (state == RUN);

    // Integer r0 is hard-wired: writes and reserves aimed at it are dropped here.
    assign wr_act = ready && wen && !(!wfmode && waddr == '0);
    assign rs_act = ready && resv_en && !(!resv_fmode && resv_addr == '0);

    // NOTE: next-state logic assigns defaults first so no path leaves a variable unassigned (no latch).
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            CLEAR: begin
                idx_nxt = idx + AW'(1);
                if (idx == AW'(NREG - 1)) begin
                    state_nxt = RUN;
                    idx_nxt   = '0;
                end
            end
            RUN:     state_nxt = RUN;
            default: state_nxt = CLEAR;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= CLEAR;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // NOTE: storage has no reset; the CLEAR sweep zeroes it instead, keeping the array reset-free.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[0][idx] <= '0;
            mem[1][idx] <= '0;
        end else if (rstn && wr_act) begin
            mem[wfmode][waddr] <= wdata;
        end
    end

    // Reserve is applied after the write-clear so a same-edge reserve leaves the bit set.
    always_comb begin
        busy_nxt = busy;
        if (wr_act) busy_nxt[wfmode][waddr] = 1'b0;
        if (rs_act) busy_nxt[resv_fmode][resv_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) busy <= '0;
        else       busy <= busy_nxt;
    end

    always_comb begin
        rdata_nxt = '0;
        rbusy_nxt = '0;
        if (ready) begin
            for (int i = 0; i < NREAD; i++) begin
                if (!rfmode[i] && raddr[i*AW +: AW] == '0) begin
                    rdata_nxt[i*XLEN +: XLEN] = '0;
                    rbusy_nxt[i]              = 1'b0;
                end else begin
                    if (wr_act && wfmode == rfmode[i] && waddr == raddr[i*AW +: AW])
                        rdata_nxt[i*XLEN +: XLEN] = wdata;
                    else
                        rdata_nxt[i*XLEN +: XLEN] = mem[rfmode[i]][raddr[i*AW +: AW]];
                    rbusy_nxt[i] = busy_nxt[rfmode[i]][raddr[i*AW +: AW]];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rdata <= '0;
            rbusy <= '0;
        end else begin
            rdata <= rdata_nxt;
            rbusy <= rbusy_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_banked.sv
// Directed self-checking bench for regfile_banked: sweep, int r0, bypass, scoreboard,
// mid-operation reset and multi-port reads against hand-computed values.
module tb_regfile_banked;

    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int NREAD = 3;
    localparam int AW    = 5;

    logic                  clk = 1'b0;
    logic                  rstn;
    logic                  ready;
    logic [NREAD-1:0]      rfmode;
    logic [NREAD*AW-1:0]   raddr;
    logic [NREAD*XLEN-1:0] rdata;
    logic [NREAD-1:0]      rbusy;
    logic                  wen;
    logic                  wfmode;
    logic [AW-1:0]         waddr;
    logic [XLEN-1:0]       wdata;
    logic                  resv_en;
    logic                  resv_fmode;
    logic [AW-1:0]         resv_addr;

    int passed = 0;
    int total  = 0;

    regfile_banked #(.XLEN(XLEN), .NREG(NREG), .NREAD(NREAD)) dut (
        .clk(clk), .rstn(rstn), .ready(ready),
        .rfmode(rfmode), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .wen(wen), .wfmode(wfmode), .waddr(waddr), .wdata(wdata),
        .resv_en(resv_en), .resv_fmode(resv_fmode), .resv_addr(resv_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Advance one edge; outputs are sampled and inputs changed 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int i, input logic fm, input logic [AW-1:0] a);
        rfmode[i]        = fm;
        raddr[i*AW +: AW] = a;
    endtask

    function automatic logic [XLEN-1:0] rd(input int i);
        return rdata[i*XLEN +: XLEN];
    endfunction

    task automatic idle_inputs();
        wen = 1'b0; wfmode = 1'b0; waddr = '0; wdata = '0;
        resv_en = 1'b0; resv_fmode = 1'b0; resv_addr = '0;
    endtask

    // Runs the 32-edge sweep after rstn is released, checking ready timing and held-zero reads.
    task automatic run_sweep(input string tag);
        int early_ready = 0;
        int early_data  = 0;
        rstn = 1'b1;
        for (int k = 1; k <= NREG; k++) begin
            tick();
            if (k < NREG) begin
                if (ready !== 1'b0) early_ready++;
                if (rdata !== '0 || rbusy !== '0) early_data++;
            end
        end
        total++;
        if (early_ready !== 0) $display("FAIL %s_ready_low: ready high on %0d sweep edges, expected 0", tag, early_ready);
        else passed++;
        total++;
        if (early_data !== 0) $display("FAIL %s_held_zero: nonzero rdata/rbusy on %0d sweep edges, expected 0", tag, early_data);
        else passed++;
        total++;
        if (ready !== 1'b1) $display("FAIL %s_ready_high: ready=%b after edge %0d, expected 1", tag, ready, NREG);
        else passed++;
    endtask

    task automatic check_all_zero(input string tag);
        for (int a = 0; a < NREG; a++) begin
            set_port(0, 1'b0, AW'(a));
            set_port(1, 1'b1, AW'(a));
            set_port(2, 1'b1, AW'(a));
            tick();
            total++;
            if (rd(0) !== '0 || rd(1) !== '0 || rbusy !== '0)
                $display("FAIL %s_zero r%0d: int=%h float=%h rbusy=%b, expected 0/0/000", tag, a, rd(0), rd(1), rbusy);
            else passed++;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rfmode = '0; raddr = '0;
        rstn = 1'b0;
        repeat (3) tick();
        total++;
        if (ready !== 1'b0 || rdata !== '0 || rbusy !== '0)
            $display("FAIL reset_state: ready=%b rdata=%h rbusy=%b, expected 0/0/0", ready, rdata, rbusy);
        else passed++;
        // A write issued during the sweep must be ignored.
        wen = 1'b1; wfmode = 1'b1; waddr = 5'd4; wdata = 32'hFFFF_FFFF;
        set_port(0, 1'b1, 5'd4);
        run_sweep("sweep");
        idle_inputs();
        check_all_zero("sweep");
    endtask

    task automatic test_int_r0();
        idle_inputs();
        set_port(0, 1'b0, 5'd0);
        set_port(1, 1'b0, 5'd0);
        set_port(2, 1'b1, 5'd1);
        wen = 1'b1; wfmode = 1'b0; waddr = 5'd0; wdata = 32'hDEAD_BEEF;
        tick();
        total++;
        if (rd(0) !== 32'h0 || rbusy[0] !== 1'b0)
            $display("FAIL int_r0_write_bypass: data=%h busy=%b, expected 0/0", rd(0), rbusy[0]);
        else passed++;
        wen = 1'b0;
        resv_en = 1'b1; resv_fmode = 1'b0; resv_addr = 5'd0;
        tick();
        total++;
        if (rd(1) !== 32'h0 || rbusy[1] !== 1'b0)
            $display("FAIL int_r0_reserve: data=%h busy=%b, expected 0/0", rd(1), rbusy[1]);
        else passed++;
        resv_en = 1'b0;
        set_port(0, 1'b1, 5'd0);
        wen = 1'b1; wfmode = 1'b1; waddr = 5'd0; wdata = 32'h3F80_0000;
        tick();
        total++;
        if (rd(0) !== 32'h3F80_0000)
            $display("FAIL float_r0_bypass: data=%h, expected 3f800000", rd(0));
        else passed++;
        wen = 1'b0;
        tick();
        total++;
        if (rd(0) !== 32'h3F80_0000 || rd(1) !== 32'h0)
            $display("FAIL float_r0_stored: float=%h int=%h, expected 3f800000/0", rd(0), rd(1));
        else passed++;
    endtask

    task automatic test_bypass();
        idle_inputs();
        set_port(0, 1'b1, 5'd5);
        set_port(1, 1'b0, 5'd5);
        set_port(2, 1'b1, 5'd6);
        wen = 1'b1; wfmode = 1'b1; waddr = 5'd5; wdata = 32'h1234_5678;
        tick();
        total++;
        if (rd(0) !== 32'h1234_5678 || rd(1) !== 32'h0)
            $display("FAIL bypass_same_cycle: f5=%h i5=%h, expected 12345678/0", rd(0), rd(1));
        else passed++;
        wen = 1'b0;
        tick();
        total++;
        if (rd(0) !== 32'h1234_5678 || rd(1) !== 32'h0)
            $display("FAIL bypass_storage: f5=%h i5=%h, expected 12345678/0", rd(0), rd(1));
        else passed++;
    endtask

    task automatic test_scoreboard();
        idle_inputs();
        set_port(0, 1'b0, 5'd7);
        set_port(1, 1'b1, 5'd7);
        set_port(2, 1'b0, 5'd8);
        resv_en = 1'b1; resv_fmode = 1'b0; resv_addr = 5'd7;
        tick();
        total++;
        if (rbusy !== 3'b001)
            $display("FAIL reserve_visible: rbusy=%b, expected 001", rbusy);
        else passed++;
        resv_en = 1'b0;
        repeat (3) tick();
        total++;
        if (rbusy[0] !== 1'b1)
            $display("FAIL reserve_held: rbusy0=%b, expected 1", rbusy[0]);
        else passed++;
        wen = 1'b1; wfmode = 1'b0; waddr = 5'd7; wdata = 32'd9;
        tick();
        total++;
        if (rd(0) !== 32'd9 || rbusy[0] !== 1'b0)
            $display("FAIL write_clears_busy: data=%h busy=%b, expected 9/0", rd(0), rbusy[0]);
        else passed++;
        wdata = 32'h0000_0077;
        resv_en = 1'b1; resv_fmode = 1'b0; resv_addr = 5'd7;
        tick();
        total++;
        if (rd(0) !== 32'h0000_0077 || rbusy[0] !== 1'b1)
            $display("FAIL write_reserve_same_edge: data=%h busy=%b, expected 77/1", rd(0), rbusy[0]);
        else passed++;
        idle_inputs();
        tick();
        total++;
        if (rd(0) !== 32'h0000_0077 || rbusy[0] !== 1'b1)
            $display("FAIL write_reserve_stored: data=%h busy=%b, expected 77/1", rd(0), rbusy[0]);
        else passed++;
    endtask

    task automatic test_all_ports();
        idle_inputs();
        set_port(0, 1'b0, 5'd1);
        set_port(1, 1'b0, 5'd1);
        set_port(2, 1'b0, 5'd1);
        wen = 1'b1; wfmode = 1'b0; waddr = 5'd9; wdata = 32'hA5A5_A5A5;
        tick();
        wen = 1'b0;
        for (int i = 0; i < NREAD; i++) set_port(i, 1'b0, 5'd9);
        tick();
        for (int i = 0; i < NREAD; i++) begin
            total++;
            if (rd(i) !== 32'hA5A5_A5A5)
                $display("FAIL all_ports_p%0d: data=%h, expected a5a5a5a5", i, rd(i));
            else passed++;
        end
    endtask

    task automatic test_mid_reset();
        idle_inputs();
        for (int a = 1; a <= 3; a++) begin
            wen = 1'b1; wfmode = 1'b0; waddr = AW'(a); wdata = 32'h100 + a;
            tick();
        end
        wen = 1'b0;
        resv_en = 1'b1; resv_fmode = 1'b1; resv_addr = 5'd2;
        set_port(0, 1'b0, 5'd2);
        set_port(1, 1'b1, 5'd2);
        tick();
        total++;
        if (rd(0) !== 32'h102 || rbusy[1] !== 1'b1)
            $display("FAIL pre_reset_state: i2=%h f2busy=%b, expected 102/1", rd(0), rbusy[1]);
        else passed++;
        resv_en = 1'b0;
        rstn = 1'b0;
        tick();
        total++;
        if (ready !== 1'b0 || rdata !== '0 || rbusy !== '0)
            $display("FAIL mid_reset_state: ready=%b rdata=%h rbusy=%b, expected 0/0/0", ready, rdata, rbusy);
        else passed++;
        run_sweep("resweep");
        check_all_zero("resweep");
    endtask

    initial begin
        test_reset();
        test_int_r0();
        test_bypass();
        test_scoreboard();
        test_all_ports();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
